// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit: operands and command in, status and results out.
interface muldiv_unit_if #(
    parameter int N = 8
);
    logic         start;
    logic         op;
    logic         signed_op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result_lo;
    logic [N-1:0] result_hi;
    logic         dbz;

    modport master (
        output start, op, signed_op, a, b,
        input  busy, done, result_lo, result_hi, dbz
    );

    modport slave (
        input  start, op, signed_op, a, b,
        output busy, done, result_lo, result_hi, dbz
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiplier (shift-add) and restoring divider, one bit per cycle.
// Two's-complement mode is compiled in only when MULDIV_SIGNED_EN is defined.
module muldiv_unit #(
    parameter int N = 8
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(N);

    // IDLE: waiting | RUN: one radix-2 step per cycle | DONE: results valid, done pulse
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic          op_q, op_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic [N-1:0]  res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic          dbz_q, dbz_d;

    logic          a_neg, b_neg;
    logic [N-1:0]  a_mag, b_mag;

`ifdef MULDIV_SIGNED_EN
    assign a_neg = bus.signed_op & bus.a[N-1];
    assign b_neg = bus.signed_op & bus.b[N-1];
`else
    logic unused_signed_op;
    assign unused_signed_op = bus.signed_op;
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif
    assign a_mag = a_neg ? (~bus.a + N'(1)) : bus.a;
    assign b_mag = b_neg ? (~bus.b + N'(1)) : bus.b;

    logic [N:0]     mul_sum, div_shift, div_diff;
    logic           div_ge;
    logic [N-1:0]   step_hi, step_lo, fin_hi, fin_lo;
    logic [2*N-1:0] prod, prod_neg;

    // Borrow out of the N+1 bit trial subtraction decides the quotient bit.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[N-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[N];
        if (op_q) begin
            step_hi = div_ge ? div_diff[N-1:0] : div_shift[N-1:0];
            step_lo = {lo_q[N-2:0], div_ge};
        end else begin
            step_hi = mul_sum[N:1];
            step_lo = {mul_sum[0], lo_q[N-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_neg = ~prod + (2*N)'(1);
        fin_hi   = step_hi;
        fin_lo   = step_lo;
        if (!op_q && neg_lo_q) begin
            fin_hi = prod_neg[2*N-1:N];
            fin_lo = prod_neg[N-1:0];
        end
        if (op_q && neg_lo_q) fin_lo = ~step_lo + N'(1);
        if (op_q && neg_hi_q) fin_hi = ~step_hi + N'(1);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;

        case (state_q)
            RUN: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    res_lo_d = fin_lo;
                    res_hi_d = fin_hi;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.start && (state_q == IDLE || state_q == DONE)) begin
            if (bus.op && bus.b == '0) begin
                state_d  = DONE;
                res_lo_d = '1;
                res_hi_d = bus.a;
                dbz_d    = 1'b1;
            end else begin
                state_d  = RUN;
                cnt_d    = CW'(N - 1);
                hi_d     = '0;
                lo_d     = a_mag;
                opnd_d   = b_mag;
                op_d     = bus.op;
                neg_lo_d = a_neg ^ b_neg;
                neg_hi_d = a_neg;
                dbz_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            op_q     <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result_lo = res_lo_q;
    assign bus.result_hi = res_hi_q;
    assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit (N=8) against an integer-arithmetic scoreboard.
module tb_muldiv_unit;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.N(N)) bus ();
    muldiv_unit #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [N-1:0] lo;
        logic [N-1:0] hi;
        logic         dbz;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic op, input logic sgn,
                                   input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t r;
        int   sa, sb, p, q, m;
        logic use_s;
`ifdef MULDIV_SIGNED_EN
        use_s = sgn;
`else
        use_s = sgn & 1'b0;
`endif
        sa    = use_s ? int'($signed(a)) : int'(a);
        sb    = use_s ? int'($signed(b)) : int'(b);
        r.dbz = 1'b0;
        if (!op) begin
            p    = sa * sb;
            r.hi = p[15:8];
            r.lo = p[7:0];
        end else if (b == '0) begin
            r.lo  = '1;
            r.hi  = a;
            r.dbz = 1'b1;
        end else begin
            q    = sa / sb;
            m    = sa % sb;
            r.lo = q[7:0];
            r.hi = m[7:0];
        end
        return r;
    endfunction

    task automatic drive(input logic op, input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.op        = op;
        bus.signed_op = sgn;
        bus.a         = a;
        bus.b         = b;
        bus.start     = 1'b1;
        exp_q.push_back(model(op, sgn, a, b));
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Early cycles of an operation may carry ignored start requests with scrambled operands.
    task automatic stir(input logic pulse, input int cyc);
        if (pulse && cyc < 4) begin
            bus.start = 1'b1;
            bus.op    = ~bus.op;
            bus.a     = ~bus.a;
            bus.b     = '0;
        end else begin
            bus.start = 1'b0;
        end
    endtask

    task automatic finish_op(input int exp_cyc, input logic pulse, input string tag);
        int           cyc;
        int           nbusy;
        logic         held_ok;
        logic [N-1:0] lo0, hi0;
        exp_t         e;
        @(negedge clk);
        cyc     = 1;
        nbusy   = 0;
        held_ok = 1'b1;
        lo0     = bus.result_lo;
        hi0     = bus.result_hi;
        stir(pulse, cyc);
        while (!bus.done && cyc < 40) begin
            if (bus.busy) nbusy++;
            if (bus.result_lo !== lo0 || bus.result_hi !== hi0) held_ok = 1'b0;
            @(negedge clk);
            cyc++;
            stir(pulse, cyc);
        end
        check({tag, ":done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, ":busy_cycles"}, 32'(nbusy), 32'(exp_cyc - 1));
        check({tag, ":busy_in_done"}, 32'(bus.busy), 32'd0);
        check({tag, ":held_in_run"}, 32'(held_ok), 32'd1);
        check({tag, ":sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, ":result_lo"}, 32'(bus.result_lo), 32'(e.lo));
            check({tag, ":result_hi"}, 32'(bus.result_hi), 32'(e.hi));
            check({tag, ":dbz"}, 32'(bus.dbz), 32'(e.dbz));
        end
    endtask

    initial begin
        logic         saw_done;
        int           nb;
        logic         r_op;
        logic [N-1:0] r_a, r_b;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 1'b0;
        bus.signed_op = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(negedge clk);
        check("rst:busy", 32'(bus.busy), 32'd0);
        check("rst:done", 32'(bus.done), 32'd0);
        check("rst:result_lo", 32'(bus.result_lo), 32'd0);
        check("rst:result_hi", 32'(bus.result_hi), 32'd0);
        check("rst:dbz", 32'(bus.dbz), 32'd0);

        // start presented in the first cycle after reset release
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'd13, 8'd11);
        finish_op(N + 1, 1'b0, "mul_13x11");
        idle(2);
        drive(1'b0, 1'b0, 8'hFF, 8'hFF);
        finish_op(N + 1, 1'b0, "mul_ff_ff");
        drive(1'b0, 1'b0, 8'h00, 8'h37);
        finish_op(N + 1, 1'b0, "b2b_mul_zero_a");
        drive(1'b0, 1'b0, 8'h37, 8'h00);
        finish_op(N + 1, 1'b0, "b2b_mul_zero_b");

        idle(1);
        drive(1'b1, 1'b0, 8'd200, 8'd7);
        finish_op(N + 1, 1'b0, "div_200_7");
        drive(1'b1, 1'b0, 8'h5A, 8'h00);
        finish_op(1, 1'b0, "div_by_zero");
        drive(1'b1, 1'b0, 8'd10, 8'd3);
        finish_op(N + 1, 1'b0, "div_dbz_clear");
        drive(1'b1, 1'b0, 8'hFF, 8'h01);
        finish_op(N + 1, 1'b0, "div_ff_1");

        idle(2);
        drive(1'b1, 1'b0, 8'd5, 8'd9);
        finish_op(N + 1, 1'b1, "div_small_pulsed");
        drive(1'b0, 1'b0, 8'hA5, 8'h3C);
        finish_op(N + 1, 1'b1, "mul_pulsed");

        // reset in the 4th RUN cycle, with start pulses before it
        idle(1);
        drive(1'b0, 1'b0, 8'h21, 8'h13);
        saw_done = 1'b0;
        nb       = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
            if (bus.busy) nb++;
            if (c <= 2) begin
                bus.start = 1'b1;
                bus.op    = 1'b1;
                bus.a     = 8'h44;
                bus.b     = 8'h00;
            end else begin
                bus.start = 1'b0;
            end
            if (c == 4) rst = 1'b1;
        end
        @(negedge clk);
        check("abort:busy_cycles", 32'(nb), 32'd4);
        check("abort:no_done", 32'(saw_done), 32'd0);
        check("abort:busy", 32'(bus.busy), 32'd0);
        check("abort:done", 32'(bus.done), 32'd0);
        check("abort:result_lo", 32'(bus.result_lo), 32'd0);
        check("abort:result_hi", 32'(bus.result_hi), 32'd0);
        check("abort:dbz", 32'(bus.dbz), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'd100, 8'd9);
        finish_op(N + 1, 1'b0, "after_abort");

        // without signed support these run unsigned; the model follows the same build option
        idle(1);
        drive(1'b0, 1'b1, 8'hFA, 8'h05);
        finish_op(N + 1, 1'b0, "smul_m6x5");
        drive(1'b1, 1'b1, 8'hF9, 8'h02);
        finish_op(N + 1, 1'b0, "sdiv_m7_2");
        drive(1'b1, 1'b1, 8'h80, 8'hFF);
        finish_op(N + 1, 1'b0, "sdiv_min_m1");
        drive(1'b1, 1'b1, 8'h07, 8'hFE);
        finish_op(N + 1, 1'b0, "sdiv_7_m2");
        drive(1'b0, 1'b1, 8'hF9, 8'hFA);
        finish_op(N + 1, 1'b0, "smul_m7xm6");

        for (int i = 0; i < 6; i++) begin
            r_op = 1'(i % 2);
            r_a  = N'($urandom);
            r_b  = (i == 3) ? '0 : N'($urandom);
            idle(i % 2);
            drive(r_op, 1'(i / 3), r_a, r_b);
            finish_op((r_op && r_b == '0) ? 1 : N + 1, 1'(i % 3 == 0), "rand");
        end

        bus.start = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
